// File: rtl/vfd_therm_decoder.sv
// vfd_therm_decoder: thermometer code to registered fill level with a 2-entry level-change event buffer.
// Optional legality checking of the thermometer code is enabled by defining VFD_THERM_ERRCHK_EN.
module vfd_therm_decoder #(
  parameter int P_WIDTH = 5,
  localparam int LW = $clog2(P_WIDTH + 1)
) (
  input  logic               clk_tb,
  input  logic               rst_tb,
  input  logic               i_clear,
  input  logic [P_WIDTH-1:0] i_therm,
  output logic [LW-1:0]      o_level,
  output logic               o_full,
  output logic               o_error,
  output logic               o_overflow,
  output logic               o_evt_valid,
  output logic [LW-1:0]      o_evt_level,
  input  logic               i_evt_ready
);
  logic [P_WIDTH-1:0] r_in;
  logic [LW-1:0]      r_level, r_f0, r_f1;
  logic [1:0]         r_count;
  logic               r_error, r_overflow;
  logic [LW-1:0]      w_k, w_f0_n, w_f1_n;
  logic [1:0]         w_cnt_n;
  logic               w_legal, w_push, w_pop, w_drop;
  always_comb begin
    w_k = '0;
    for (int i = 0; i < P_WIDTH; i++) w_k = w_k + LW'(r_in[i]);
  end
`ifdef VFD_THERM_ERRCHK_EN
  // legal code with k ones is all-ones shifted right by k, inverted
  assign w_legal = r_in == ~({P_WIDTH{1'b1}} >> w_k);
`else
  assign w_legal = 1'b1;
`endif
  assign w_push = w_legal && w_k != r_level;
  assign w_pop  = r_count != 2'd0 && i_evt_ready;
  // pop first, then place the push into the first free slot of the post-pop FIFO
  always_comb begin
    w_f0_n  = r_f0;
    w_f1_n  = r_f1;
    w_cnt_n = r_count;
    w_drop  = 1'b0;
    if (w_pop) begin
      w_f0_n  = r_f1;
      w_cnt_n = r_count - 2'd1;
    end
    if (w_push) begin
      if (w_cnt_n == 2'd0) begin
        w_f0_n  = w_k;
        w_cnt_n = 2'd1;
      end else if (w_cnt_n == 2'd1) begin
        w_f1_n  = w_k;
        w_cnt_n = 2'd2;
      end else w_drop = 1'b1;
    end
  end
  always_ff @(posedge clk_tb or negedge rst_tb) begin
    if (!rst_tb) begin
      r_in       <= '0;
      r_level    <= '0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
      r_f0       <= '0;
      r_f1       <= '0;
    end else if (i_clear) begin
      r_in       <= '0;
      r_level    <= '0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
      r_f0       <= '0;
      r_f1       <= '0;
    end else begin
      r_in    <= i_therm;
      r_count <= w_cnt_n;
      r_f0    <= w_f0_n;
      r_f1    <= w_f1_n;
      if (w_legal) r_level <= w_k;
      else r_error <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end
  assign o_level     = r_level;
  assign o_full      = r_level == LW'(P_WIDTH);
  assign o_error     = r_error;
  assign o_overflow  = r_overflow;
  assign o_evt_valid = r_count != 2'd0;
  assign o_evt_level = r_count != 2'd0 ? r_f0 : '0;
endmodule

// File: tb/tb_vfd_therm_decoder.sv
// tb_vfd_therm_decoder: directed plus randomized checks against a queue-based reference model.
module tb_vfd_therm_decoder;
  localparam int W = 5;
  logic         clk_tb = 1'b0;
  logic         rst_tb = 1'b0;
  logic         i_clear = 1'b0;
  logic [W-1:0] i_therm = '0;
  logic         i_evt_ready = 1'b0;
  logic [2:0]   o_level, o_evt_level;
  logic         o_full, o_error, o_overflow, o_evt_valid;
  int n_chk = 0;
  int n_fail = 0;
  int m_in, m_level, m_error, m_ovf;
  int q[$];
  vfd_therm_decoder #(.P_WIDTH(W)) dut (
    .clk_tb(clk_tb), .rst_tb(rst_tb), .i_clear(i_clear), .i_therm(i_therm),
    .o_level(o_level), .o_full(o_full), .o_error(o_error), .o_overflow(o_overflow),
    .o_evt_valid(o_evt_valid), .o_evt_level(o_evt_level), .i_evt_ready(i_evt_ready)
  );
  always #5 clk_tb = ~clk_tb;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_in = 0; m_level = 0; m_error = 0; m_ovf = 0;
    q.delete();
  endtask
  task automatic check_all(input string tag);
    check({tag, " level"}, int'(o_level), m_level);
    check({tag, " full"}, int'(o_full), int'(m_level == W));
    check({tag, " error"}, int'(o_error), m_error);
    check({tag, " overflow"}, int'(o_overflow), m_ovf);
    check({tag, " valid"}, int'(o_evt_valid), int'(q.size() > 0));
    check({tag, " evt_level"}, int'(o_evt_level), q.size() > 0 ? q[0] : 0);
  endtask
  function automatic int therm_of(input int k);
    return ((1 << k) - 1) << (W - k);
  endfunction
  task automatic step(input int therm, input bit ready, input bit clr, input string tag);
    int k;
    bit legal, pop;
    i_therm = W'(therm);
    i_evt_ready = ready;
    i_clear = clr;
    @(posedge clk_tb);
    k = $countones(m_in);
`ifdef VFD_THERM_ERRCHK_EN
    legal = m_in == therm_of(k);
`else
    legal = 1'b1;
`endif
    pop = ready && q.size() > 0;
    if (clr) model_reset();
    else begin
      if (pop) void'(q.pop_front());
      if (legal && k != m_level) begin
        if (q.size() < 2) q.push_back(k);
        else m_ovf = 1;
      end
      if (legal) m_level = k;
      else m_error = 1;
      m_in = therm;
    end
    #1;
    check_all(tag);
  endtask
  task automatic async_reset(input string tag);
    #2 rst_tb = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk_tb);
    rst_tb = 1'b1;
  endtask
  initial begin
    model_reset();
    #1;
    check_all("reset");
    #12 rst_tb = 1'b1;
    @(negedge clk_tb);
    repeat (5) step(0, 1'b0, 1'b0, "idle");
    for (int k = 1; k <= W; k++) step(therm_of(k), 1'b1, 1'b0, "fill");
    repeat (3) step(therm_of(W), 1'b1, 1'b0, "full");
    step(0, 1'b1, 1'b1, "clear");
    step(0, 1'b1, 1'b0, "clear2");
    for (int k = 1; k <= 3; k++) step(therm_of(k), 1'b0, 1'b0, "ovf");
    repeat (3) step(therm_of(3), 1'b0, 1'b0, "ovf_hold");
    repeat (3) step(therm_of(3), 1'b1, 1'b0, "drain");
    step(0, 1'b1, 1'b1, "clear3");
    repeat (3) step(therm_of(1), 1'b1, 1'b0, "lvl1");
    repeat (3) step(5'b10100, 1'b0, 1'b0, "illegal");
    step(therm_of(1), 1'b0, 1'b0, "back1");
    step(therm_of(1), 1'b0, 1'b0, "back1b");
    step(0, 1'b0, 1'b1, "clear4");
    for (int k = 1; k <= 4; k++) step(therm_of(k), 1'b0, 1'b0, "prefill");
    for (int k = 3; k >= 1; k--) step(therm_of(k), 1'b1, 1'b0, "pushpop");
    repeat (3) step(therm_of(1), 1'b1, 1'b0, "pp_drain");
    step(0, 1'b0, 1'b1, "clear5");
    for (int k = 1; k <= 3; k++) step(therm_of(k), 1'b0, 1'b0, "prerst");
    step(therm_of(3), 1'b0, 1'b0, "prerst2");
    async_reset("async_rst");
    step(therm_of(2), 1'b1, 1'b0, "post_rst");
    for (int k = 3; k <= W; k++) step(therm_of(k), 1'b0, 1'b0, "to5");
    step(therm_of(W), 1'b0, 1'b0, "at5");
    step(therm_of(W), 1'b0, 1'b1, "clear_at5");
    step(therm_of(W), 1'b0, 1'b0, "after_clr");
    for (int n = 0; n < 600; n++) begin
      int t;
      t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                      : therm_of(int'($urandom_range(0, W)));
      step(t, 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0, "rand");
      if ($urandom_range(0, 150) == 0) async_reset("rand_rst");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vfd_therm_decoder.md
# vfd_therm_decoder

Downstream stage of the shift register: consumes its P_WIDTH-bit thermometer result (fills from MSB, e.g. 00000 → 10000 → 11000 …), converts it to a registered binary fill level, flags full and illegal codes, and emits a level-change event stream through a 2-entry valid/ready buffer. Sits between the shift register's output and any consumer that needs fill-level change notifications rather than raw bits.

## Interface
- P_WIDTH, 5, thermometer width; LW = $clog2(P_WIDTH+1) derived (3 for default)
- clk_tb  in  1  clock, all state on rising edge
- rst_tb  in  1  reset, asynchronous, active-low; clock clk_tb
- i_clear  in  1  synchronous clear, highest priority after reset
- i_therm  in  P_WIDTH  thermometer code from shift register
- o_level  out  LW  registered fill level (count of ones)
- o_full  out  1  o_level == P_WIDTH
- o_error  out  1  sticky: illegal code seen
- o_overflow  out  1  sticky: event dropped, buffer full
- o_evt_valid  out  1  event buffer non-empty
- o_evt_level  out  LW  level carried by head event
- i_evt_ready  in  1  consumer accepts head event when high with o_evt_valid

## Operation
- Stage 1: r_in <= i_therm every cycle.
- Legal code: k ones in MSBs, P_WIDTH−k zeros below, k = 0..P_WIDTH (P_WIDTH+1 legal values).
- Stage 2: legal r_in → o_level <= k; illegal → o_level holds, o_error <= 1.
- Event push when new legal k ≠ current o_level; event payload = k. No event for unchanged level or illegal code.
- Buffer: 2-entry FIFO, count 0/1/2. Pop = o_evt_valid & i_evt_ready.
- Push with count<2 → stored. Push with count==2 and no pop → event dropped, o_overflow <= 1. Push + pop with count==2 → accepted, count stays 2.
- Pop with no push → count decrements; pop on empty impossible (valid low).
- o_evt_level = oldest entry; undefined-free: 0 when empty.
- i_clear: r_in, o_level, o_error, o_overflow, FIFO count all to 0; no event generated for that cycle or for the level transition it causes.
- Sticky flags cleared only by rst_tb or i_clear.

## Timing
- Reset (rst_tb low, async): o_level=0, o_full=0, o_error=0, o_overflow=0, o_evt_valid=0, o_evt_level=0, r_in=0.
- Reset mid-operation: all state lost immediately; buffered events discarded; first cycle after release r_in samples i_therm.
- Latency: i_therm sampled at edge N → o_level/o_full/o_error updated at edge N+1; pushed event visible on o_evt_valid after edge N+1 if buffer was empty.
- Head event popped at edge M → next entry (or valid low) after edge M.
- Shift register advancing one bit per cycle yields one event per cycle; consumer holding i_evt_ready low fills buffer in 2 cycles, third change overflows.
- o_full combinational from o_level register (no extra cycle).

## Configuration
- VFD_THERM_ERRCHK_EN defined: legality check active as above.
- Not defined: no legality check; o_level <= popcount(r_in) for any code, events on any popcount change, o_error tied 0.

## Test plan
- Reset then i_therm=00000 held 5 cycles → o_level=0, o_evt_valid=0, all flags 0.
- i_evt_ready=1, i_therm steps 10000,11000,11100,11110,11111 one per cycle → events 1,2,3,4,5 in order, one per cycle; o_full=1 two edges after 11111 applied.
- i_evt_ready=0, steps to levels 1,2,3 → buffer holds 1,2; o_overflow=1; then ready=1 → pops 1 then 2, valid low.
- i_therm=10100 (illegal) from level 1 → o_error=1, o_level stays 1, no event; without VFD_THERM_ERRCHK_EN → o_level=2, event 2, o_error=0.
- Buffer full, i_evt_ready=1 with simultaneous level change → no overflow, count stays 2, order preserved.
- rst_tb low mid-fill at level 3 with 2 buffered events → all outputs 0 asynchronously; i_clear=1 at level 5 → same zeros next edge, no event.
